// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared state encoding and COUNT width for the skid register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int COUNT_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipeState_t;

  // Occupancy reported on COUNT for a given state.
  function automatic logic [COUNT_W-1:0] stateCount(input pipeState_t s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stall_counter.sv
// ============================================================================
// Module      : pipe_stall_counter
// Description : Saturating count of cycles where output is offered but refused.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_counter #(
  parameter int STATS_W = 16
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               STALL_EVENT,
  output logic [STATS_W-1:0] STALL_COUNT
);

  logic [STATS_W-1:0] r_count;

  // Cleared by RESET only; FLUSH intentionally has no effect here.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (STALL_EVENT && (r_count != {STATS_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign STALL_COUNT = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry skid register with flush, stall and optional
//               stall statistics (enable with macro PIPE_SKID_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 38,
  parameter int STATS_W = 16
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               FLUSH,
  input  logic               STALL,
  input  logic               IN_VALID,
  input  logic [WIDTH-1:0]   IN_DATA,
  output logic               IN_READY,
  output logic               OUT_VALID,
  output logic [WIDTH-1:0]   OUT_DATA,
  input  logic               OUT_READY,
  output logic [COUNT_W-1:0] COUNT,
  output logic [STATS_W-1:0] STALL_COUNT
);

  pipeState_t       r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_inFire;
  logic             w_outFire;

  assign IN_READY  = (r_state != FULL) && !STALL && !FLUSH;
  assign OUT_VALID = (r_state != EMPTY) && !STALL;
  assign OUT_DATA  = r_main;
  assign COUNT     = stateCount(r_state);

  assign w_inFire  = IN_VALID && IN_READY;
  assign w_outFire = OUT_VALID && OUT_READY;

  // STALL needs no branch of its own: it already masks both fire terms.
  always_ff @(posedge CLOCK) begin
    if (RESET || FLUSH) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inFire) begin
            r_state <= ONE;
            r_main  <= IN_DATA;
          end
        end
        ONE: begin
          if (w_inFire && w_outFire) begin
            r_main <= IN_DATA;
          end else if (w_inFire) begin
            r_state <= FULL;
            r_skid  <= IN_DATA;
          end else if (w_outFire) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_outFire) begin
            r_state <= ONE;
            r_main  <= r_skid;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  pipe_stall_counter #(
    .STATS_W (STATS_W)
  ) u_stallCounter (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .STALL_EVENT (OUT_VALID && !OUT_READY),
    .STALL_COUNT (STALL_COUNT)
  );
`else
  assign STALL_COUNT = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench: directed scenarios plus random traffic
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

  localparam int W  = 38;
  localparam int SW = 2;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          FLUSH = 1'b0;
  logic          STALL = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [W-1:0]  IN_DATA = '0;
  logic          IN_READY;
  logic          OUT_VALID;
  logic [W-1:0]  OUT_DATA;
  logic          OUT_READY = 1'b0;
  logic [1:0]    COUNT;
  logic [SW-1:0] STALL_COUNT;

  int nChecks = 0;
  int nFails  = 0;

  pipe_skid_reg #(
    .WIDTH   (W),
    .STATS_W (SW)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .FLUSH       (FLUSH),
    .STALL       (STALL),
    .IN_VALID    (IN_VALID),
    .IN_DATA     (IN_DATA),
    .IN_READY    (IN_READY),
    .OUT_VALID   (OUT_VALID),
    .OUT_DATA    (OUT_DATA),
    .OUT_READY   (OUT_READY),
    .COUNT       (COUNT),
    .STALL_COUNT (STALL_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // ---------------- reference model: FIFO of at most two entries ----------
  logic [W-1:0] q[$];
  logic [W-1:0] lastHead = '0;
  int           stallCnt = 0;
  bit           modelValid = 1'b0;

  always @(posedge CLOCK) begin
    bit expOv, inF, outF;
    if (RESET) begin
      q.delete();
      lastHead   = '0;
      stallCnt   = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      expOv = (q.size() > 0) && !STALL;
      inF   = IN_VALID && (q.size() < 2) && !STALL && !FLUSH;
      outF  = expOv && OUT_READY;
      if (expOv && !OUT_READY && stallCnt < (1 << SW) - 1) stallCnt++;
      if (FLUSH) begin
        q.delete();
        lastHead = '0;
      end else begin
        if (outF) void'(q.pop_front());
        if (inF) q.push_back(IN_DATA);
        if (q.size() > 0) lastHead = q[0];
      end
    end
  end

  always @(negedge CLOCK) begin
    if (modelValid) begin
      chk("model IN_READY", 64'(IN_READY), 64'((q.size() < 2) && !STALL && !FLUSH));
      chk("model OUT_VALID", 64'(OUT_VALID), 64'((q.size() > 0) && !STALL));
      chk("model OUT_DATA", 64'(OUT_DATA), 64'((q.size() > 0) ? q[0] : lastHead));
      chk("model COUNT", 64'(COUNT), 64'(q.size()));
`ifdef PIPE_SKID_STATS_EN
      chk("model STALL_COUNT", 64'(STALL_COUNT), 64'(stallCnt));
`else
      chk("model STALL_COUNT", 64'(STALL_COUNT), 64'd0);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [W-1:0] d);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    tick();
    IN_VALID = 1'b0;
  endtask

  initial begin
    logic [63:0] r64;

    // Reset with a transfer offered; it must be ignored.
    RESET = 1'b1; IN_VALID = 1'b1; IN_DATA = W'(8'h2A); OUT_READY = 1'b1;
    tick();
    chk("reset COUNT", 64'(COUNT), 64'd0);
    chk("reset OUT_VALID", 64'(OUT_VALID), 64'd0);
    chk("reset OUT_DATA", 64'(OUT_DATA), 64'd0);
    chk("reset IN_READY", 64'(IN_READY), 64'd1);
    chk("reset STALL_COUNT", 64'(STALL_COUNT), 64'd0);
    RESET = 1'b0; IN_VALID = 1'b0;

    // Streaming: one-cycle latency, full throughput.
    for (int i = 1; i <= 8; i++) begin
      IN_VALID = 1'b1; IN_DATA = W'(i);
      tick();
      chk("stream OUT_VALID", 64'(OUT_VALID), 64'd1);
      chk("stream OUT_DATA", 64'(OUT_DATA), 64'(i));
      chk("stream IN_READY", 64'(IN_READY), 64'd1);
    end
    IN_VALID = 1'b0;
    tick();
    chk("stream drained COUNT", 64'(COUNT), 64'd0);
    chk("stream drained OUT_DATA kept", 64'(OUT_DATA), 64'd8);

    // Backpressure fills the skid entry.
    OUT_READY = 1'b0;
    push(W'(4'hA));
    push(W'(4'hB));
    chk("bp COUNT full", 64'(COUNT), 64'd2);
    chk("bp IN_READY", 64'(IN_READY), 64'd0);
    OUT_READY = 1'b1;
    #1;
    chk("bp first out", 64'(OUT_DATA), 64'hA);
    tick();
    chk("bp second out", 64'(OUT_DATA), 64'hB);
    chk("bp COUNT one", 64'(COUNT), 64'd1);
    tick();
    chk("bp COUNT empty", 64'(COUNT), 64'd0);

    // Flush while full, with a competing offer.
    OUT_READY = 1'b0;
    push(W'(4'hA));
    push(W'(4'hB));
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = W'(4'hC);
    #1;
    chk("flush IN_READY", 64'(IN_READY), 64'd0);
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    chk("flush COUNT", 64'(COUNT), 64'd0);
    chk("flush OUT_DATA", 64'(OUT_DATA), 64'd0);
    OUT_READY = 1'b1;
    tick();
    chk("flush no emit", 64'(OUT_VALID), 64'd0);

    // Stall freezes a single held entry.
    OUT_READY = 1'b0;
    push(W'(4'h5));
    STALL = 1'b1; IN_VALID = 1'b1; IN_DATA = W'(8'h77); OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall OUT_VALID", 64'(OUT_VALID), 64'd0);
      chk("stall IN_READY", 64'(IN_READY), 64'd0);
      tick();
      chk("stall COUNT", 64'(COUNT), 64'd1);
    end
    STALL = 1'b0; IN_VALID = 1'b0;
    #1;
    chk("stall release OUT_VALID", 64'(OUT_VALID), 64'd1);
    chk("stall release OUT_DATA", 64'(OUT_DATA), 64'h5);
    tick();
    chk("stall release COUNT", 64'(COUNT), 64'd0);

    // Stall statistics: saturation, flush-immunity, reset clear.
    RESET = 1'b1; tick(); RESET = 1'b0;
    OUT_READY = 1'b0;
    push(W'(4'h1));
    repeat (5) tick();
`ifdef PIPE_SKID_STATS_EN
    chk("stats saturated", 64'(STALL_COUNT), 64'd3);
`else
    chk("stats tied off", 64'(STALL_COUNT), 64'd0);
`endif
    FLUSH = 1'b1; tick(); FLUSH = 1'b0;
`ifdef PIPE_SKID_STATS_EN
    chk("stats after flush", 64'(STALL_COUNT), 64'd3);
`else
    chk("stats after flush", 64'(STALL_COUNT), 64'd0);
`endif
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("stats after reset", 64'(STALL_COUNT), 64'd0);

    // Random traffic with phase-varying ready bias to reach FULL often.
    for (int c = 0; c < 3000; c++) begin
      int readyPct;
      readyPct = ((c / 200) % 2 == 0) ? 35 : 85;
      r64 = {$urandom(), $urandom()};
      RESET     = ($urandom_range(0, 299) == 0);
      FLUSH     = ($urandom_range(0, 49) == 0);
      STALL     = ($urandom_range(0, 6) == 0);
      IN_VALID  = ($urandom_range(0, 99) < 70);
      IN_DATA   = r64[W-1:0];
      OUT_READY = ($urandom_range(0, 99) < readyPct);
      tick();
    end
    RESET = 1'b0; FLUSH = 1'b0; STALL = 1'b0; IN_VALID = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 38, payload bits per entry (default covers 32-bit data + 5-bit register + 1 enable).
REQ-002 SHALL have parameter: STATS_W, 16, width of the stall-cycle counter.
REQ-003 SHALL have port: CLOCK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: FLUSH  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port: STALL  input  1  freeze both sides; no accept, no emit.
REQ-007 SHALL have port: IN_VALID  input  1  upstream offers IN_DATA.
REQ-008 SHALL have port: IN_DATA  input  WIDTH  upstream payload.
REQ-009 SHALL have port: IN_READY  output  1  block can accept this cycle.
REQ-010 SHALL have port: OUT_VALID  output  1  OUT_DATA is valid.
REQ-011 SHALL have port: OUT_DATA  output  WIDTH  head entry payload.
REQ-012 SHALL have port: OUT_READY  input  1  downstream accepts this cycle.
REQ-013 SHALL have port: COUNT  output  2  entries held (0..2).
REQ-014 SHALL have port: STALL_COUNT  output  STATS_W  cycles with OUT_VALID=1 and OUT_READY=0.

Function
REQ-015 SHALL define in_fire = IN_VALID & IN_READY and out_fire = OUT_VALID & OUT_READY.
REQ-016 SHALL drive IN_READY = (state != FULL) & !STALL & !FLUSH; combinational on STALL/FLUSH, otherwise from registered state only.
REQ-017 SHALL drive OUT_VALID = (state != EMPTY) & !STALL.
REQ-018 SHALL hold state machine EMPTY/ONE/FULL with main and skid entry registers; OUT_DATA = main.
REQ-019 SHALL transition EMPTY: in_fire -> ONE, main <= IN_DATA; else EMPTY.
REQ-020 SHALL transition ONE: in_fire & out_fire -> ONE, main <= IN_DATA; in_fire only -> FULL, skid <= IN_DATA; out_fire only -> EMPTY; neither -> ONE.
REQ-021 SHALL transition FULL: out_fire -> ONE, main <= skid; else FULL (in_fire impossible).
REQ-022 SHALL give 1-cycle latency IN->OUT and sustain one transfer per cycle while OUT_READY=1.
REQ-023 SHALL preserve order; no entry dropped or duplicated except by FLUSH/RESET.
REQ-024 SHALL on FLUSH go to EMPTY, zero main and skid, and discard any IN_DATA offered that cycle; FLUSH overrides STALL and handshakes.
REQ-025 SHALL while STALL=1 (no FLUSH) hold state, main, skid unchanged.
REQ-026 SHALL keep main value when draining to EMPTY (not zeroed); only RESET/FLUSH zero it.
REQ-027 SHALL drive COUNT = 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-028 SHALL on RESET=1 at a rising edge: state EMPTY, main=0, skid=0, STALL_COUNT=0; outputs after edge IN_READY=1 (if STALL=0), OUT_VALID=0, OUT_DATA=0, COUNT=0.
REQ-029 SHALL give RESET priority over FLUSH, STALL and handshakes, including mid-transfer.

Configuration
REQ-030 SHALL with PIPE_SKID_STATS_EN defined increment STALL_COUNT each cycle OUT_VALID=1 & OUT_READY=0, saturating at all-ones, cleared by RESET only (not FLUSH).
REQ-031 SHALL without PIPE_SKID_STATS_EN tie STALL_COUNT to 0 and infer no counter flops.

Structure
REQ-032 SHALL place state typedef (EMPTY/ONE/FULL) and COUNT width constant in shared package pipe_pkg.
REQ-033 SHALL implement the counter as sub-module pipe_stall_counter, instantiated only under PIPE_SKID_STATS_EN.

Verification
REQ-034 SHALL test reset: RESET=1 one cycle with IN_VALID=1, IN_DATA=0x2A -> COUNT=0, OUT_VALID=0, OUT_DATA=0.
REQ-035 SHALL test streaming: OUT_READY=1, push 0x01..0x08 back-to-back -> same sequence at OUT one cycle later, IN_READY stays 1.
REQ-036 SHALL test backpressure: OUT_READY=0, push 0xA, 0xB -> COUNT=2, IN_READY=0; OUT_READY=1 -> 0xA then 0xB, COUNT back to 0.
REQ-037 SHALL test flush: FULL with 0xA/0xB, FLUSH=1 with IN_VALID=1, IN_DATA=0xC -> next cycle COUNT=0, OUT_DATA=0, 0xC never emitted.
REQ-038 SHALL test stall: ONE holding 0x5, STALL=1 for 3 cycles with IN_VALID=1 -> OUT_VALID=0, IN_READY=0, state unchanged; release -> 0x5 emitted first.
REQ-039 SHALL test stats (macro on, STATS_W=2): 5 cycles OUT_VALID=1 and OUT_READY=0 -> STALL_COUNT=3 (saturated); FLUSH leaves it 3; RESET clears to 0.
